// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   md_op_e    : operation encodings as presented on the op port
//   md_state_e : sequencer state encoding
//   MD_*_LAT   : default busy latencies
//   md_max     : helper used to size the latency counter
package md_pkg;

  localparam int DATA_W         = 32;
  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic int md_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath.
//   a, b   : latched operands
//   op     : latched operation
//   hi_res : MULT* upper product half, DIV* remainder
//   lo_res : MULT* lower product half, DIV* quotient
// A zero divisor yields don't-care results; the sequencer discards them.
module md_core
  import md_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  md_op_e            op,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res
);

  logic signed [2*DATA_W-1:0] a_s64;
  logic signed [2*DATA_W-1:0] b_s64;
  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic signed [DATA_W:0]     a_s33;
  logic signed [DATA_W:0]     b_s33;
  logic signed [DATA_W:0]     quo_s;
  logic signed [DATA_W:0]     rem_s;
  logic        [DATA_W-1:0]   b_nz;
  logic        [DATA_W-1:0]   quo_u;
  logic        [DATA_W-1:0]   rem_u;
  logic                       unused_div_msb;

  // Divisor forced non-zero so the divider never sees zero.
  assign b_nz   = (b == '0) ? DATA_W'(1) : b;

  assign a_s64  = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_s64  = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_s = a_s64 * b_s64;
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // One extra bit keeps most-negative / -1 representable.
  assign a_s33  = {a[DATA_W-1], a};
  assign b_s33  = {b_nz[DATA_W-1], b_nz};
  assign quo_s  = a_s33 / b_s33;
  assign rem_s  = a_s33 % b_s33;
  assign quo_u  = a / b_nz;
  assign rem_u  = a % b_nz;

  assign unused_div_msb = ^{quo_s[DATA_W], rem_s[DATA_W]};

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op)
      MD_MULT:  {hi_res, lo_res} = prod_s;
      MD_MULTU: {hi_res, lo_res} = prod_u;
      MD_DIV: begin
        hi_res = rem_s[DATA_W-1:0];
        lo_res = quo_s[DATA_W-1:0];
      end
      default: begin
        hi_res = rem_u;
        lo_res = quo_u;
      end
    endcase
  end

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer for the five-stage pipeline.
//   clk, reset : pipeline clock, asynchronous active-high reset
//   start, op  : E-stage MULT/MULTU/DIV/DIVU issue and its operation
//   mthi, mtlo : E-stage writes of A into HI / LO (idle only)
//   A, B       : forwarded rs / rt operands
//   md_use_D   : D-stage instruction touches the multiply/divide unit
//   busy       : operation in flight
//   stall      : decode freeze request
//   HI, LO     : architectural HI/LO
module hilo_md_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              md_use_D,
  output logic              busy,
  output logic              stall,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int CNT_W = $clog2(md_max(MUL_LAT, DIV_LAT) + 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_p0, a_d;
  logic [DATA_W-1:0] b_p0, b_d;
  md_op_e            op_p0, op_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_res, lo_res;
  logic              div_zero;

  md_core u_core (
    .a      (a_p0),
    .b      (b_p0),
    .op     (op_p0),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  assign div_zero = op_p0[1] && (b_p0 == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_p0;
    b_d     = b_p0;
    op_d    = op_p0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = md_op_e'(op);
          cnt_d   = op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          state_d = ST_RUN;
        end else if (mthi) begin
          hi_d = A;
        end else if (mtlo) begin
          lo_d = A;
        end
      end
      default: begin
        // Issue-side inputs are ignored here; only the countdown matters.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!div_zero) begin
            hi_d = hi_res;
            lo_d = lo_res;
          end
        end
      end
    endcase
  end

  // Operand latch / sequencer state boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_p0    <= '0;
      b_p0    <= '0;
      op_p0   <= MD_MULT;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_p0    <= a_d;
      b_p0    <= b_d;
      op_p0   <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign stall = md_use_D & (start | busy);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: doc/hilo_md_ctrl.md
# hilo_md_ctrl

Multi-cycle multiply/divide sequencer owning the HI/LO register pair of the five-stage pipeline. It accepts a MULT/MULTU/DIV/DIVU issue from the execute stage and holds the unit busy for a fixed latency. It generates the stall request that freezes decode while a HI/LO-using instruction waits. It also services MTHI/MTLO writes and presents HI/LO for MFHI/MFLO forwarding into the MEM/WB path.

## Interface
Parameters:
- MUL_LAT, default 5: busy cycles for MULT/MULTU.
- DIV_LAT, default 10: busy cycles for DIV/DIVU.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU.
- op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- mthi  in  1  E-stage MTHI; write A to HI.
- mtlo  in  1  E-stage MTLO; write A to LO.
- A  in  32  rs operand, forwarded value.
- B  in  32  rt operand, forwarded value.
- md_use_D  in  1  D-stage instruction is any of MULT*, DIV*, MFHI, MFLO, MTHI, MTLO.
- busy  out  1  operation in flight.
- stall  out  1  stall request to hazard unit: md_use_D & (start | busy).
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

## Operation
- States: IDLE, RUN. Reset -> IDLE, busy=0, HI=0, LO=0, internal counter=0, latched operands=0.
- IDLE, start=1 at edge: latch A, B, op; counter <= MUL_LAT or DIV_LAT by op[1]; -> RUN.
- RUN: counter decrements each edge. At the edge where counter reaches 0, write HI/LO from the latched result and return to IDLE.
- MULT: {HI,LO} = signed 64-bit A*B. MULTU: unsigned 64-bit product.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder, sign of dividend. DIVU: unsigned quotient/remainder.
- Divide by zero (B=0): latency unchanged, HI/LO left unchanged at completion.
- Result is computed from latched operands only. Changes on A/B during RUN have no effect.
- IDLE, mthi=1: HI <= A at edge. IDLE, mtlo=1: LO <= A at edge. No state change.
- Priority when inputs overlap (illegal from a correct decoder): start > mthi > mtlo; only the winner acts.
- start, mthi or mtlo asserted during RUN: ignored. The stall term guarantees this never occurs in a correct pipeline.
- HI/LO outputs always reflect the current architectural value. They never show a partial result.

## Timing
- Edge E0 samples start. busy=1 from E0 until edge E0+LAT, where LAT is MUL_LAT or DIV_LAT.
- At edge E0+LAT, HI/LO update and busy falls together.
- MFHI/MFLO in D issues in the cycle after E0+LAT and sees the new value.
- stall is combinational. It is asserted in the E0 cycle itself via start, so a dependent instruction directly behind the mult/div is held.
- Back-to-back MULTs: the second sits in D stalled. It enters E in the cycle after busy falls, giving LAT+1 cycles of issue spacing.
- mthi/mtlo: HI/LO visible the cycle after the write edge. Latency 1.
- reset asserted mid-RUN: operation abandoned, busy=0, HI=LO=0 immediately, no completion write afterward.

## Structure
- Shared package md_pkg: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state encoding, default latency constants.
- One natural sub-module: md_core, purely combinational. It takes latched A, B, op and produces 64-bit {hi_res, lo_res}, isolating the signed/unsigned arithmetic from the sequencer.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)+1).

## Test plan
- MULT A=32'hFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
- MULTU A=32'hFFFFFFFF, B=2 -> after 5 cycles HI=1, LO=32'hFFFFFFFE.
- DIV A=-7, B=2 -> busy 10 cycles; LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). DIVU A=7, B=0 -> after 10 cycles HI/LO unchanged.
- MULT issued with md_use_D=1 (MFLO behind) -> stall=1 for E0 cycle plus 5 busy cycles; MFLO reads the product the cycle after busy falls. md_use_D=0 -> stall stays 0 while busy=1.
- MTHI A=32'h12345678 while idle -> HI=32'h12345678 next cycle. MTLO while busy -> LO unchanged; completion value wins.
- reset pulse at RUN cycle 3 of a DIV -> busy=0, HI=LO=0 immediately and stay 0 through former completion cycle.
